// File: rtl/shot_controller.sv
// Keyboard-to-bullet front end: edge-triggered fire with cooldown,
// finite magazine, manual/automatic reload and held aim direction.
module shot_controller #(
  parameter logic [7:0]  FIRE_KEY        = 8'h2C,
  parameter logic [7:0]  RELOAD_KEY      = 8'h15,
  parameter logic [7:0]  KEY_LEFT        = 8'h04,
  parameter logic [7:0]  KEY_RIGHT       = 8'h07,
  parameter logic [7:0]  KEY_DOWN        = 8'h16,
  parameter logic [7:0]  KEY_UP          = 8'h1A,
  parameter int unsigned AMMO_MAX        = 8,
  parameter int unsigned COOLDOWN_FRAMES = 15,
  parameter int unsigned RELOAD_FRAMES   = 120
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       shoot,
  output logic [1:0] Direction,
  output logic [3:0] ammo,
  output logic       reloading,
  output logic       ready
);

  localparam logic [3:0] AMMO_FULL = 4'(AMMO_MAX);
  localparam logic [7:0] COOL_LD   = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0] RELD_LD   = 8'(RELOAD_FRAMES - 1);

  typedef enum logic [1:0] {
    S_READY,
    S_COOL,
    S_RELOAD
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] ammo_q, ammo_d;
  logic [1:0] dir_q, dir_d;
  logic       shoot_q, shoot_d;
  logic       rld_q, rld_d;
  logic       rdy_q, rdy_d;
  logic       fire_prev_q;
  logic       reload_prev_q;

  logic fire_hit;
  logic rel_hit;
  logic fire_edge;
  logic reload_edge;

  assign fire_hit    = (keycode == FIRE_KEY);
  assign rel_hit     = (keycode == RELOAD_KEY);
  assign fire_edge   = fire_hit && !fire_prev_q;
  assign reload_edge = rel_hit && !reload_prev_q;

  // Direction follows the last direction key in every state.
  always_comb begin
    dir_d = dir_q;
    unique case (1'b1)
      keycode == KEY_LEFT:  dir_d = 2'b00;
      keycode == KEY_RIGHT: dir_d = 2'b01;
      keycode == KEY_DOWN:  dir_d = 2'b10;
      keycode == KEY_UP:    dir_d = 2'b11;
      default:              dir_d = dir_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ammo_d  = ammo_q;
    shoot_d = 1'b0;
    unique case (state_q)
      S_READY: begin
        if (fire_edge && ammo_q != 4'd0) begin
          shoot_d = 1'b1;
          ammo_d  = ammo_q - 4'd1;
          cnt_d   = COOL_LD;
          state_d = S_COOL;
        end else if (reload_edge && ammo_q < AMMO_FULL) begin
          cnt_d   = RELD_LD;
          state_d = S_RELOAD;
        end
      end
      S_COOL: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (ammo_q != 4'd0) begin
          state_d = S_READY;
        end else begin
          cnt_d   = RELD_LD;
          state_d = S_RELOAD;
        end
      end
      S_RELOAD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          ammo_d  = AMMO_FULL;
          state_d = S_READY;
        end
      end
      default: begin
        state_d = S_READY;
        cnt_d   = 8'd0;
      end
    endcase
    rld_d = (state_d == S_RELOAD);
    rdy_d = (state_d == S_READY) && (ammo_d != 4'd0);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_READY;
      cnt_q         <= 8'd0;
      ammo_q        <= AMMO_FULL;
      dir_q         <= 2'b11;
      shoot_q       <= 1'b0;
      rld_q         <= 1'b0;
      rdy_q         <= 1'b1;
      fire_prev_q   <= 1'b0;
      reload_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ammo_q        <= ammo_d;
      dir_q         <= dir_d;
      shoot_q       <= shoot_d;
      rld_q         <= rld_d;
      rdy_q         <= rdy_d;
      fire_prev_q   <= fire_hit;
      reload_prev_q <= rel_hit;
    end
  end

  assign shoot     = shoot_q;
  assign Direction = dir_q;
  assign ammo      = ammo_q;
  assign reloading = rld_q;
  assign ready     = rdy_q;

endmodule

// File: tb/tb_shot_controller.sv
// Bench for shot_controller: per-frame expected outputs are queued
// as stimulus is driven and compared after each frame edge.
module tb_shot_controller;

  localparam logic [7:0] FIRE = 8'h2C;
  localparam logic [7:0] RELK = 8'h15;
  localparam logic [7:0] KA   = 8'h04;
  localparam logic [7:0] KD   = 8'h07;
  localparam logic [7:0] KS   = 8'h16;
  localparam logic [7:0] KW   = 8'h1A;

  typedef struct packed {
    logic       sh;
    logic [1:0] dir;
    logic [3:0] am;
    logic       rl;
    logic       rd;
  } obs_t;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       shoot;
  logic [1:0] Direction;
  logic [3:0] ammo;
  logic       reloading;
  logic       ready;

  obs_t obs;
  obs_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;

  assign obs = {shoot, Direction, ammo, reloading, ready};

  shot_controller dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .shoot     (shoot),
    .Direction (Direction),
    .ammo      (ammo),
    .reloading (reloading),
    .ready     (ready)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic obs_t mk(logic s, logic [1:0] d,
                              logic [3:0] a, logic r, logic y);
    return {s, d, a, r, y};
  endfunction

  task automatic tick(input logic [7:0] k);
    keycode = k;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    keycode = 8'h00;
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    keycode = 8'h00;
    Reset = 1'b1;
    #2;
    sb.push_back(mk(1'b0, 2'b11, 4'd8, 1'b0, 1'b1));
    e = sb.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_async got %b want %b", obs, e);
    end
    @(posedge frame_clk);
    #1;
    sb.push_back(mk(1'b0, 2'b11, 4'd8, 1'b0, 1'b1));
    e = sb.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_hold got %b want %b", obs, e);
    end
    Reset = 1'b0;
    sb.push_back(mk(1'b0, 2'b11, 4'd8, 1'b0, 1'b1));
    tick(8'h00);
    e = sb.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_release got %b want %b", obs, e);
    end
  endtask

  // Fire held for 20 frames: one shot, no refire on return to READY.
  task automatic test_fire_hold();
    obs_t e;
    for (int i = 1; i <= 24; i++) begin
      sb.push_back(mk(i == 1, 2'b11, 4'd7, 1'b0, i >= 16));
      tick(i <= 20 ? FIRE : 8'h00);
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL fire_hold f%0d got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_cooldown();
    obs_t e;
    logic [7:0] k;
    logic [3:0] a;
    logic y;
    for (int i = 1; i <= 36; i++) begin
      k = (i == 1 || i == 4 || i == 17) ? FIRE : 8'h00;
      a = (i < 17) ? 4'd6 : 4'd5;
      y = (i == 16) || (i >= 32);
      sb.push_back(mk(i == 1 || i == 17, 2'b11, a, 1'b0, y));
      tick(k);
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL cooldown f%0d got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_direction();
    obs_t e;
    logic [7:0] k;
    logic [1:0] d;
    for (int i = 1; i <= 20; i++) begin
      case (i)
        1: k = KW;
        2: k = KS;
        4: k = FIRE;
        5: k = KA;
        6: k = KD;
        default: k = 8'h00;
      endcase
      if (i == 1) d = 2'b11;
      else if (i <= 4) d = 2'b10;
      else if (i == 5) d = 2'b00;
      else d = 2'b01;
      sb.push_back(mk(i == 4, d, (i < 4) ? 4'd5 : 4'd4,
                      1'b0, (i < 4) || (i >= 19)));
      tick(k);
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL direction f%0d got %b want %b", i, obs, e);
      end
    end
  endtask

  // Eight shots 20 frames apart, then cooldown into auto-reload.
  task automatic test_magazine();
    obs_t e;
    logic [7:0] k;
    logic s, r, y;
    int a;
    do_reset();
    for (int i = 1; i <= 285; i++) begin
      s = (i <= 141) && (i % 20 == 1);
      k = (s || i == 180 || i == 200) ? FIRE : 8'h00;
      if (i >= 276) a = 8;
      else if (i >= 141) a = 0;
      else a = 7 - (i - 1) / 20;
      r = (i >= 156) && (i <= 275);
      if (i >= 276) y = 1'b1;
      else if (i >= 141) y = 1'b0;
      else y = ((i - 1) % 20) >= 15;
      sb.push_back(mk(s, 2'b11, 4'(a), r, y));
      tick(k);
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL magazine f%0d got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_manual_reload();
    obs_t e;
    logic [7:0] k;
    logic s, r, y;
    logic [3:0] a;
    for (int i = 1; i <= 195; i++) begin
      s = (i == 11 || i == 31 || i == 51);
      if (i == 1 || i == 71) k = RELK;
      else if (s || i == 100) k = FIRE;
      else k = 8'h00;
      if (i < 11) a = 4'd8;
      else if (i < 31) a = 4'd7;
      else if (i < 51) a = 4'd6;
      else if (i < 191) a = 4'd5;
      else a = 4'd8;
      r = (i >= 71) && (i <= 190);
      y = (i < 11) || (i >= 26 && i <= 30) ||
          (i >= 46 && i <= 50) || (i >= 66 && i <= 70) ||
          (i >= 191);
      sb.push_back(mk(s, 2'b11, a, r, y));
      tick(k);
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL manual_reload f%0d got %b want %b", i, obs, e);
      end
    end
  endtask

  // Reset on the 60th reload frame, then a clean first shot.
  task automatic test_reset_mid_reload();
    obs_t e;
    logic [7:0] k;
    logic y;
    for (int i = 1; i <= 79; i++) begin
      if (i == 1) k = KA;
      else if (i == 2) k = FIRE;
      else if (i == 20) k = RELK;
      else k = 8'h00;
      y = (i == 1) || (i >= 17 && i <= 19);
      sb.push_back(mk(i == 2, 2'b00, (i < 2) ? 4'd8 : 4'd7,
                      i >= 20, y));
      tick(k);
      e = sb.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL mid_reload f%0d got %b want %b", i, obs, e);
      end
    end
    Reset = 1'b1;
    #1;
    sb.push_back(mk(1'b0, 2'b11, 4'd8, 1'b0, 1'b1));
    e = sb.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mid_reset_async got %b want %b", obs, e);
    end
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    sb.push_back(mk(1'b0, 2'b11, 4'd8, 1'b0, 1'b1));
    tick(8'h00);
    e = sb.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL mid_reset_idle got %b want %b", obs, e);
    end
    sb.push_back(mk(1'b1, 2'b11, 4'd7, 1'b0, 1'b0));
    tick(FIRE);
    e = sb.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_reset_fire got %b want %b", obs, e);
    end
    sb.push_back(mk(1'b0, 2'b11, 4'd7, 1'b0, 1'b0));
    tick(8'h00);
    e = sb.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_reset_pulse got %b want %b", obs, e);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fire_hold();
    test_cooldown();
    test_direction();
    test_magazine();
    test_manual_reload();
    test_reset_mid_reload();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
